beat_time_gen: RTL and testbench

//  Song time base: emits the cur_time tick count and beat index, the inverse of the

---
 rtl/beat_pkg.sv | 14 +
 rtl/beat_time_gen_if.sv | 27 ++
 rtl/tick_prescaler.sv | 24 ++
 rtl/beat_time_gen.sv | 129 ++++++++++++
 tb/tb_beat_time_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/beat_pkg.sv
// Shared types for the song time base: playback state and song-length helper.
package beat_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } beat_state_t;

  function automatic int song_ticks(input int beats, input int dur);
    return beats * dur;
  endfunction

endpackage

// File: rtl/beat_time_gen_if.sv
// Control/status bundle of the song time base; master = controller, slave = beat_time_gen.
interface beat_time_gen_if #(
  parameter int TIME_BITS = 16,
  parameter int BEAT_BITS = 8
);
  logic                 start;
  logic                 pause;
  logic                 stop;
  logic                 seek_valid;
  logic [BEAT_BITS-1:0] seek_beat;
  logic                 seek_ready;
  logic [TIME_BITS-1:0] cur_time;
  logic [BEAT_BITS-1:0] cur_beat;
  logic                 beat_pulse;
  logic                 song_done;
  logic                 playing;

  modport master (
    output start, pause, stop, seek_valid, seek_beat,
    input  seek_ready, cur_time, cur_beat, beat_pulse, song_done, playing
  );

  modport slave (
    input  start, pause, stop, seek_valid, seek_beat,
    output seek_ready, cur_time, cur_beat, beat_pulse, song_done, playing
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into time ticks; o_tc is high on the last cycle of each tick while enabled.
module tick_prescaler #(
  parameter int CYCLES_PER_TICK = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);
  localparam int            CW   = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_TICK - 1);

  logic [CW-1:0] r_cnt;

  // A clear wins over the terminal count so a seek or stop never also ticks.
  assign o_tc = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/beat_time_gen.sv
// Song time base: tick/beat counters, playback FSM and seek datapath.
// Define BEAT_LOOP_EN to loop playback at end of song instead of stopping.
module beat_time_gen
  import beat_pkg::*;
#(
  parameter int TIME_BITS       = 16,
  parameter int BEAT_BITS       = 8,
  parameter int BEAT_DURATION   = 48,
  parameter int CYCLES_PER_TICK = 1000,
  parameter int SONG_BEATS      = 64
) (
  input logic           clk,
  input logic           rst,
  beat_time_gen_if.slave bus
);
  localparam int                   SONG_TICKS = song_ticks(SONG_BEATS, BEAT_DURATION);
  localparam int                   PH_W       = (BEAT_DURATION > 1) ? $clog2(BEAT_DURATION) : 1;
  localparam logic [TIME_BITS-1:0] LAST_TICK  = TIME_BITS'(SONG_TICKS - 1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT  = BEAT_BITS'(SONG_BEATS - 1);
  localparam logic [PH_W-1:0]      LAST_PH    = PH_W'(BEAT_DURATION - 1);

  if (BEAT_DURATION < 1 || CYCLES_PER_TICK < 1 || SONG_BEATS < 1) begin : g_bad_size
    $error("beat_time_gen: BEAT_DURATION, CYCLES_PER_TICK and SONG_BEATS must be >= 1");
  end
  if (longint'(SONG_TICKS) > (longint'(1) << TIME_BITS) ||
      longint'(SONG_BEATS) > (longint'(1) << BEAT_BITS)) begin : g_bad_width
    $error("beat_time_gen: song does not fit TIME_BITS/BEAT_BITS");
  end

  beat_state_t          r_state, w_state_nxt;
  logic [TIME_BITS-1:0] r_time;
  logic [BEAT_BITS-1:0] r_beat;
  logic [PH_W-1:0]      r_phase;
  logic                 r_beat_pulse, r_song_done;
  logic                 w_seek, w_tc, w_end, w_start_stopped;
  logic [BEAT_BITS-1:0] w_seek_beat;
  logic [TIME_BITS-1:0] w_seek_time;

  assign bus.seek_ready  = !bus.stop;
  assign w_seek          = bus.seek_valid && !bus.stop;
  assign w_end           = w_tc && (r_time == LAST_TICK);
  assign w_start_stopped = (r_state == STOPPED) && bus.start;
  assign w_seek_beat     = (bus.seek_beat > LAST_BEAT) ? LAST_BEAT : bus.seek_beat;
  assign w_seek_time     = TIME_BITS'(w_seek_beat) * TIME_BITS'(BEAT_DURATION);

  tick_prescaler #(.CYCLES_PER_TICK(CYCLES_PER_TICK)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == PLAYING),
    .i_clr(bus.stop || w_seek),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= STOPPED;
    else     r_state <= w_state_nxt;
  end

  // A seek never blocks the pause/start of the same cycle, only stop does.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.stop) begin
      w_state_nxt = STOPPED;
    end else begin
      case (r_state)
        STOPPED: if (bus.start) w_state_nxt = PLAYING;
        PLAYING: begin
`ifdef BEAT_LOOP_EN
          if (bus.pause) w_state_nxt = PAUSED;
`else
          if (w_end)          w_state_nxt = STOPPED;
          else if (bus.pause) w_state_nxt = PAUSED;
`endif
        end
        PAUSED:  if (bus.start) w_state_nxt = PLAYING;
        default: w_state_nxt = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time       <= '0;
      r_beat       <= '0;
      r_phase      <= '0;
      r_beat_pulse <= 1'b0;
      r_song_done  <= 1'b0;
    end else begin
      r_beat_pulse <= 1'b0;
      r_song_done  <= 1'b0;
      if (bus.stop) begin
        r_time  <= '0;
        r_beat  <= '0;
        r_phase <= '0;
      end else if (w_seek) begin
        r_time       <= w_seek_time;
        r_beat       <= w_seek_beat;
        r_phase      <= '0;
        r_beat_pulse <= (w_seek_beat != r_beat) || w_start_stopped;
      end else begin
        if (w_start_stopped) r_beat_pulse <= 1'b1;
        if (w_end) begin
          r_time      <= '0;
          r_beat      <= '0;
          r_phase     <= '0;
          r_song_done <= 1'b1;
`ifdef BEAT_LOOP_EN
          r_beat_pulse <= 1'b1;
`endif
        end else if (w_tc) begin
          r_time <= r_time + 1'b1;
          if (r_phase == LAST_PH) begin
            r_phase      <= '0;
            r_beat       <= r_beat + 1'b1;
            r_beat_pulse <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
      end
    end
  end

  assign bus.cur_time   = r_time;
  assign bus.cur_beat   = r_beat;
  assign bus.beat_pulse = r_beat_pulse;
  assign bus.song_done  = r_song_done;
  assign bus.playing    = (r_state == PLAYING);
endmodule

// File: tb/tb_beat_time_gen.sv
// Scoreboard bench for beat_time_gen: directed playback scenarios plus random control traffic.
module tb_beat_time_gen;
  localparam int TB = 8, BB = 4, BD = 3, CPT = 4, SB = 4;
  localparam int S_STOP = 0, S_PLAY = 1, S_PAUSE = 2;
`ifdef BEAT_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic [TB-1:0] t;
    logic [BB-1:0] b;
    logic          p;
    logic          d;
    logic          pl;
    logic          rdy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  obs_t sbq[$];

  // Reference model: time in ticks, cycles into current tick, beat derived by division.
  int m_state, m_time, m_pre;
  bit m_pulse, m_done;

  beat_time_gen_if #(.TIME_BITS(TB), .BEAT_BITS(BB)) bif();

  beat_time_gen #(
    .TIME_BITS(TB), .BEAT_BITS(BB), .BEAT_DURATION(BD),
    .CYCLES_PER_TICK(CPT), .SONG_BEATS(SB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_STOP; m_time = 0; m_pre = 0; m_pulse = 0; m_done = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit sp, input bit sv, input int sb);
    int  old_beat, nb;
    bit  tick, ended;
    old_beat = m_time / BD;
    m_pulse = 0; m_done = 0; ended = 0;
    if (sp) begin
      m_state = S_STOP; m_time = 0; m_pre = 0;
    end else begin
      tick = (m_state == S_PLAY) && (m_pre == CPT - 1);
      if (sv) begin
        nb = (sb > SB - 1) ? SB - 1 : sb;
        m_time = nb * BD; m_pre = 0;
        m_pulse = (nb != old_beat);
      end else if (m_state == S_PLAY) begin
        if (tick) begin
          m_pre = 0;
          if (m_time == SB * BD - 1) begin
            m_time = 0; m_done = 1;
            if (LOOP) m_pulse = 1; else ended = 1;
          end else begin
            m_time++;
            m_pulse = (m_time % BD == 0);
          end
        end else begin
          m_pre++;
        end
      end
      if (m_state == S_STOP && st) begin
        m_state = S_PLAY; m_pulse = 1;
      end else if (m_state == S_PLAY) begin
        if (ended)   m_state = S_STOP;
        else if (pa) m_state = S_PAUSE;
      end else if (m_state == S_PAUSE && st) begin
        m_state = S_PLAY;
      end
    end
  endtask

  task automatic cyc(input bit st = 0, input bit pa = 0, input bit sp = 0,
                     input bit sv = 0, input int sb = 0);
    obs_t e;
    @(negedge clk);
    bif.start = st; bif.pause = pa; bif.stop = sp; bif.seek_valid = sv;
    bif.seek_beat = sb[BB-1:0];
    model_step(st, pa, sp, sv, sb);
    e.t = TB'(m_time); e.b = BB'(m_time / BD); e.p = m_pulse; e.d = m_done;
    e.pl = (m_state == S_PLAY); e.rdy = !sp;
    sbq.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 200 && m_time != target; k++) cyc();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_time"}, bif.cur_time, 0);
    chk({nm, "_beat"}, bif.cur_beat, 0);
    chk({nm, "_pulse"}, bif.beat_pulse, 0);
    chk({nm, "_done"}, bif.song_done, 0);
    chk({nm, "_playing"}, bif.playing, 0);
  endtask

  // Monitor: the DUT presents a fresh observation after every clock edge.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (!rst && sbq.size() > 0) begin
      e = sbq.pop_front();
      a.t = bif.cur_time; a.b = bif.cur_beat; a.p = bif.beat_pulse; a.d = bif.song_done;
      a.pl = bif.playing; a.rdy = bif.seek_ready;
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got t=%0d b=%0d p=%0b d=%0b pl=%0b rdy=%0b want t=%0d b=%0d p=%0b d=%0b pl=%0b rdy=%0b",
                 $time, a.t, a.b, a.p, a.d, a.pl, a.rdy, e.t, e.b, e.p, e.d, e.pl, e.rdy);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.start = 0; bif.pause = 0; bif.stop = 0; bif.seek_valid = 0; bif.seek_beat = '0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of playback.
    cyc(1);
    run_to(7);
    settle();
    chk("t1_reach7", bif.cur_time, 7);
    bif.start = 0; bif.pause = 0; bif.stop = 0; bif.seek_valid = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("t1_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Start, then beats 1..3 land on ticks 3, 6, 9.
    cyc(1);
    settle();
    chk("t2_start_pulse", bif.beat_pulse, 1);
    chk("t2_playing", bif.playing, 1);
    for (int k = 1; k <= 3; k++) begin
      run_to(3 * k);
      settle();
      chk("t2_beat", bif.cur_beat, k);
      chk("t2_beat_pulse", bif.beat_pulse, 1);
    end
    cyc(0, 0, 1);

    // Pause mid-tick, hold, resume finishes the partial tick.
    cyc(1);
    run_to(5);
    cyc();
    cyc(0, 1);
    repeat (20) cyc();
    settle();
    chk("t3_frozen", bif.cur_time, 5);
    cyc(1);
    cyc();
    cyc();
    settle();
    chk("t3_resume_time", bif.cur_time, 6);
    chk("t3_resume_beat", bif.cur_beat, 2);
    chk("t3_resume_pulse", bif.beat_pulse, 1);
    cyc(0, 0, 1);

    // Seek while playing, clamped seek, stop blocks seek.
    cyc(1);
    run_to(1);
    cyc(0, 0, 0, 1, 2);
    settle();
    chk("t4_seek_time", bif.cur_time, 6);
    chk("t4_seek_beat", bif.cur_beat, 2);
    chk("t4_seek_pulse", bif.beat_pulse, 1);
    cyc(0, 0, 0, 1, 9);
    settle();
    chk("t4_clamp_beat", bif.cur_beat, 3);
    chk("t4_clamp_time", bif.cur_time, 9);
    cyc(0, 0, 1, 1, 2);
    settle();
    chk("t4_ready_low", bif.seek_ready, 0);
    chk("t4_stop_time", bif.cur_time, 0);
    chk("t4_stopped", bif.playing, 0);

    // End of song.
    cyc(1);
    run_to(11);
    for (int k = 0; k < 10 && !m_done; k++) cyc();
    settle();
    chk("t5_wrap_time", bif.cur_time, 0);
    chk("t5_done", bif.song_done, 1);
    chk("t5_playing", bif.playing, 32'(LOOP));
    chk("t5_pulse", bif.beat_pulse, 32'(LOOP));
    cyc(0, 0, 1);

    // Stop while paused, then restart from zero.
    cyc(1);
    run_to(4);
    cyc(0, 1);
    cyc(0, 0, 1);
    cyc(1);
    settle();
    chk("t6_start_pulse", bif.beat_pulse, 1);
    repeat (3) cyc();
    settle();
    chk("t6_time_hold", bif.cur_time, 0);
    cyc();
    settle();
    chk("t6_time_one", bif.cur_time, 1);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
    end
    cyc();
    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
